// File: rtl/line_buffer_window_stream_if.sv
// rtl/line_buffer_window_stream_if.sv - pixel-in / window-out handshake bundle
interface line_buffer_window_stream_if #(
    parameter int P_COLUMNS     = 640,
    parameter int P_ROWS        = 480,
    parameter int P_PIXEL_DEPTH = 8,
    parameter int P_KERNEL      = 3
);
    logic [P_PIXEL_DEPTH-1:0]                     I_PIXEL;
    logic                                         I_VALID;
    logic                                         O_READY;
    logic [P_KERNEL*P_KERNEL*P_PIXEL_DEPTH-1:0]   O_WINDOW;
    logic                                         O_VALID;
    logic                                         I_READY;
    logic [$clog2(P_COLUMNS)-1:0]                 O_COLUMN;
    logic [$clog2(P_ROWS)-1:0]                    O_ROW;
    logic                                         O_LAST;

    modport slave (
        input  I_PIXEL, I_VALID, I_READY,
        output O_READY, O_WINDOW, O_VALID, O_COLUMN, O_ROW, O_LAST
    );

    modport master (
        output I_PIXEL, I_VALID, I_READY,
        input  O_READY, O_WINDOW, O_VALID, O_COLUMN, O_ROW, O_LAST
    );
endinterface

// File: rtl/line_buffer_window_stream.sv
// rtl/line_buffer_window_stream.sv - raster pixel stream to zero-padded KxK window stream
module line_buffer_window_stream #(
    parameter int P_COLUMNS     = 640,
    parameter int P_ROWS        = 480,
    parameter int P_PIXEL_DEPTH = 8,
    parameter int P_KERNEL      = 3
) (
    input  logic I_CLK,
    input  logic I_RESET,
    line_buffer_window_stream_if.slave bus
);
    localparam int K  = P_KERNEL;
    localparam int H  = (P_KERNEL - 1) / 2;
    localparam int D  = P_PIXEL_DEPTH;
    localparam int CW = $clog2(P_COLUMNS);
    localparam int RW = $clog2(P_ROWS);
    localparam logic [CW-1:0] COL_LAST = CW'(P_COLUMNS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(P_ROWS - 1);
    localparam logic [CW-1:0] H_COL    = CW'(H);
    localparam logic [RW-1:0] H_ROW    = RW'(H);

    typedef enum logic [1:0] {FILL, STREAM, FLUSH} state_t;
    typedef logic [D-1:0] pix_t;

    state_t            state;
    logic [CW-1:0]     in_col, out_col, o_column;
    logic [RW-1:0]     in_row, out_row, o_row;
    logic              o_valid, o_last;
    logic [K*K*D-1:0]  o_window, masked;
    logic              can_adv, o_ready, adv, emit, out_is_last;
    pix_t              pix_in;
    pix_t              lb   [K-1][P_COLUMNS];
    pix_t              win  [K][K];
    pix_t              nxt  [K][K];
    pix_t              colv [K];

    assign can_adv     = !o_valid || bus.I_READY;
    assign o_ready     = can_adv && (state != FLUSH);
    assign pix_in      = (state == FLUSH) ? '0 : bus.I_PIXEL;
    assign adv         = (state == FLUSH) ? (can_adv && !(o_valid && o_last))
                                          : (bus.I_VALID && o_ready);
    assign emit        = adv && (state != FILL || (in_row == H_ROW && in_col == H_COL));
    assign out_is_last = (out_row == ROW_LAST) && (out_col == COL_LAST);

    // Column entering the window: oldest row at index 0, incoming pixel at K-1.
    always_comb begin
        for (int i = 0; i < K - 1; i++) colv[i] = lb[K-2-i][in_col];
        colv[K-1] = pix_in;
    end

    // Taps are kept or zeroed purely from the centre coordinates, so wrapped
    // columns and stale line-buffer rows never leak into the output.
    always_comb begin
        masked = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K - 1; j++) nxt[i][j] = win[i][j+1];
            nxt[i][K-1] = colv[i];
        end
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                if (int'(out_row) + i >= H && int'(out_row) + i - H < P_ROWS &&
                    int'(out_col) + j >= H && int'(out_col) + j - H < P_COLUMNS)
                    masked[(K*K-1-(i*K+j))*D +: D] = nxt[i][j];
            end
        end
    end

    always_ff @(posedge I_CLK) begin
        if (adv) begin
            lb[0][in_col] <= pix_in;
            for (int k = 1; k < K - 1; k++) lb[k][in_col] <= lb[k-1][in_col];
            win <= nxt;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state    <= FILL;
            in_col   <= '0;
            in_row   <= '0;
            out_col  <= '0;
            out_row  <= '0;
            o_valid  <= 1'b0;
            o_window <= '0;
            o_column <= '0;
            o_row    <= '0;
            o_last   <= 1'b0;
        end else begin
            if (emit) begin
                o_window <= masked;
                o_column <= out_col;
                o_row    <= out_row;
                o_last   <= out_is_last;
                o_valid  <= 1'b1;
                if (out_col == COL_LAST) begin
                    out_col <= '0;
                    out_row <= out_is_last ? '0 : out_row + 1'b1;
                end else begin
                    out_col <= out_col + 1'b1;
                end
            end else if (o_valid && bus.I_READY) begin
                o_valid <= 1'b0;
                o_last  <= 1'b0;
            end

            case (state)
                FILL, STREAM: begin
                    if (adv) begin
                        in_col <= (in_col == COL_LAST) ? '0 : in_col + 1'b1;
                        if (in_col == COL_LAST) in_row <= in_row + 1'b1;
                        if (state == FILL && emit) state <= STREAM;
                        if (state == STREAM && in_row == ROW_LAST && in_col == COL_LAST)
                            state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (adv) begin
                        in_col <= (in_col == COL_LAST) ? '0 : in_col + 1'b1;
                    end else if (o_valid && o_last && bus.I_READY) begin
                        state  <= FILL;
                        in_col <= '0;
                        in_row <= '0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    assign bus.O_READY  = o_ready;
    assign bus.O_VALID  = o_valid;
    assign bus.O_WINDOW = o_window;
    assign bus.O_COLUMN = o_column;
    assign bus.O_ROW    = o_row;
    assign bus.O_LAST   = o_last;
endmodule

// File: tb/tb_line_buffer_window_stream.sv
// tb/tb_line_buffer_window_stream.sv - self-checking bench for line_buffer_window_stream
module tb_line_buffer_window_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    int checks = 0;
    int errors = 0;

    line_buffer_window_stream_if #(.P_COLUMNS(4), .P_ROWS(4), .P_PIXEL_DEPTH(8), .P_KERNEL(3)) ifa ();
    line_buffer_window_stream_if #(.P_COLUMNS(6), .P_ROWS(6), .P_PIXEL_DEPTH(8), .P_KERNEL(5)) ifb ();

    line_buffer_window_stream #(.P_COLUMNS(4), .P_ROWS(4), .P_PIXEL_DEPTH(8), .P_KERNEL(3)) dut_a (
        .I_CLK(clk), .I_RESET(rst_a), .bus(ifa));
    line_buffer_window_stream #(.P_COLUMNS(6), .P_ROWS(6), .P_PIXEL_DEPTH(8), .P_KERNEL(5)) dut_b (
        .I_CLK(clk), .I_RESET(rst_b), .bus(ifb));

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // Window around centre (r,c) of a frame whose pixel(r,c) = base + cols*r + c.
    function automatic logic [199:0] expw(int k, int cols, int rows, int base, int r, int c);
        logic [199:0] w;
        int h, rr, cc, v;
        w = '0;
        h = (k - 1) / 2;
        for (int i = 0; i < k; i++)
            for (int j = 0; j < k; j++) begin
                rr = r - h + i;
                cc = c - h + j;
                v  = (rr >= 0 && rr < rows && cc >= 0 && cc < cols) ? base + cols*rr + cc : 0;
                w[(k*k-1-(i*k+j))*8 +: 8] = 8'(v);
            end
        return w;
    endfunction

    int a_base = 1, a_idx = 0, a_acc = 0, a_ntx = 0, a_cyc = 0, a_first = -1, a_n6 = -5;
    logic [71:0] a_got [16];
    logic        a_hold = 1'b0;
    logic [76:0] a_prev;

    always @(negedge clk) begin : cmp_a
        logic [199:0] ew;
        logic exp_rdy;
        int r, c;
        a_cyc++;
        if (rst_a) begin
            a_idx = 0; a_acc = 0; a_hold = 1'b0; a_first = -1;
        end else begin
            if (a_hold)
                check("a_hold", {ifa.O_VALID, ifa.O_WINDOW, ifa.O_ROW, ifa.O_COLUMN, ifa.O_LAST},
                      {1'b1, a_prev});
            exp_rdy = (!ifa.O_VALID || ifa.I_READY) && (a_acc < 16);
            check("a_ready", ifa.O_READY, exp_rdy);
            if (ifa.O_VALID && a_first < 0) a_first = a_cyc;
            if (ifa.O_VALID && ifa.I_READY) begin
                r = a_idx / 4; c = a_idx % 4;
                ew = expw(3, 4, 4, a_base, r, c);
                check($sformatf("a_window_%0d", a_idx),
                      {ifa.O_WINDOW, ifa.O_ROW, ifa.O_COLUMN, ifa.O_LAST},
                      {ew[71:0], 2'(r), 2'(c), a_idx == 15});
                a_got[a_idx] = ifa.O_WINDOW;
                a_ntx++; a_idx++;
                if (a_idx == 16) begin a_idx = 0; a_acc = 0; end
            end
            if (ifa.I_VALID && ifa.O_READY) begin
                if (a_acc == 5) a_n6 = a_cyc;
                a_acc++;
            end
            a_hold = ifa.O_VALID && !ifa.I_READY;
            a_prev = {ifa.O_WINDOW, ifa.O_ROW, ifa.O_COLUMN, ifa.O_LAST};
        end
    end

    int b_idx = 0, b_acc = 0, b_fr = 0, b_ntx = 0, b_cyc = 0, b_last = -2, b_f2 = -1;
    logic [199:0] b_got0;

    always @(negedge clk) begin : cmp_b
        logic [199:0] ew;
        logic exp_rdy;
        int r, c;
        b_cyc++;
        if (rst_b) begin
            b_idx = 0; b_acc = 0; b_fr = 0;
        end else begin
            exp_rdy = (!ifb.O_VALID || ifb.I_READY) && (b_acc < 36);
            check("b_ready", ifb.O_READY, exp_rdy);
            if (ifb.O_VALID && ifb.I_READY) begin
                r = b_idx / 6; c = b_idx % 6;
                ew = expw(5, 6, 6, (b_fr == 0) ? 1 : 50, r, c);
                check($sformatf("b_window_f%0d_%0d", b_fr, b_idx),
                      {ifb.O_WINDOW, ifb.O_ROW, ifb.O_COLUMN, ifb.O_LAST},
                      {ew, 3'(r), 3'(c), b_idx == 35});
                if (b_idx == 0 && b_fr == 0) b_got0 = ifb.O_WINDOW;
                b_ntx++; b_idx++;
                if (b_idx == 36) begin
                    b_idx = 0; b_acc = 0;
                    if (b_fr == 0) b_last = b_cyc;
                    b_fr++;
                end
            end
            if (ifb.I_VALID && ifb.O_READY) begin
                if (b_fr == 1 && b_acc == 0) b_f2 = b_cyc;
                b_acc++;
            end
        end
    end

    task automatic send(input bit sel_b, input int base, input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            t = 0;
            if (sel_b) begin ifb.I_PIXEL = 8'(base + i); ifb.I_VALID = 1'b1; end
            else       begin ifa.I_PIXEL = 8'(base + i); ifa.I_VALID = 1'b1; end
            @(negedge clk);
            while (!(sel_b ? ifb.O_READY : ifa.O_READY) && t < 100) begin
                @(negedge clk); t++;
            end
            if (t >= 100) begin
                checks++; errors++;
                $display("FAIL send_timeout pixel %0d got no O_READY want O_READY=1", i);
            end
            @(posedge clk); #1;
        end
        if (sel_b) ifb.I_VALID = 1'b0; else ifa.I_VALID = 1'b0;
    endtask

    task automatic wait_tx(input bit sel_b, input int target);
        int t;
        t = 0;
        while (((sel_b ? b_ntx : a_ntx) < target) && t < 1000) begin
            @(negedge clk); t++;
        end
        checks++;
        if (t >= 1000) begin
            errors++;
            $display("FAIL wait_tx got %0d want %0d", sel_b ? b_ntx : a_ntx, target);
        end
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
    endtask

    int n0;
    int nz;

    initial begin
        ifa.I_VALID = 1'b0; ifa.I_PIXEL = '0; ifa.I_READY = 1'b1;
        ifb.I_VALID = 1'b0; ifb.I_PIXEL = '0; ifb.I_READY = 1'b1;
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        check("a_reset", {ifa.O_VALID, ifa.O_LAST, ifa.O_ROW, ifa.O_COLUMN, ifa.O_WINDOW, ifa.O_READY},
              {1'b0, 1'b0, 2'd0, 2'd0, 72'd0, 1'b1});
        check("b_reset", {ifb.O_VALID, ifb.O_LAST, ifb.O_ROW, ifb.O_COLUMN, ifb.O_WINDOW, ifb.O_READY},
              {1'b0, 1'b0, 3'd0, 3'd0, 200'd0, 1'b1});
        @(posedge clk); #1;

        // Frame 1, full throughput
        a_base = 1; n0 = a_ntx;
        send(0, 1, 16);
        wait_tx(0, n0 + 16);
        check("a_count", a_ntx - n0, 16);
        check("a_latency", a_first, a_n6 + 1);
        check("a_win00", a_got[0],  {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd0, 8'd5, 8'd6});
        check("a_win11", a_got[5],  {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11});
        check("a_win13", a_got[7],  {8'd3, 8'd4, 8'd0, 8'd7, 8'd8, 8'd0, 8'd11, 8'd12, 8'd0});
        check("a_win20", a_got[8],  {8'd0, 8'd5, 8'd6, 8'd0, 8'd9, 8'd10, 8'd0, 8'd13, 8'd14});
        check("a_win33", a_got[15], {8'd11, 8'd12, 8'd0, 8'd15, 8'd16, 8'd0, 8'd0, 8'd0, 8'd0});

        // Frame 2 with downstream stalls mid-stream and during the flush
        a_base = 20; n0 = a_ntx;
        fork
            send(0, 20, 16);
            begin
                repeat (9) @(posedge clk);
                #1 check("a_stall_valid", ifa.O_VALID, 1'b1);
                ifa.I_READY = 1'b0;
                repeat (3) @(posedge clk);
                #1 ifa.I_READY = 1'b1;
            end
        join
        check("a_flush_valid", ifa.O_VALID, 1'b1);
        ifa.I_READY = 1'b0;
        repeat (3) @(posedge clk);
        #1 ifa.I_READY = 1'b1;
        wait_tx(0, n0 + 16);
        check("a_bp_count", a_ntx - n0, 16);

        // Reset mid-frame, then a fresh frame must show no stale pixels
        a_base = 1;
        send(0, 1, 7);
        rst_a = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_a = 1'b0;
        @(negedge clk);
        check("a_after_reset", {ifa.O_VALID, ifa.O_READY}, 2'b01);
        @(posedge clk); #1;
        a_base = 100; n0 = a_ntx;
        send(0, 100, 16);
        wait_tx(0, n0 + 16);
        check("a_stale_count", a_ntx - n0, 16);
        check("a_stale_win00", a_got[0], {8'd0, 8'd0, 8'd0, 8'd0, 8'd100, 8'd101, 8'd0, 8'd104, 8'd105});

        // K=5 back-to-back frames
        n0 = b_ntx;
        send(1, 1, 36);
        send(1, 50, 36);
        wait_tx(1, n0 + 72);
        check("b_count", b_ntx - n0, 72);
        check("b_win00", b_got0, {80'd0,
                                  8'd0, 8'd0, 8'd1, 8'd2, 8'd3,
                                  8'd0, 8'd0, 8'd7, 8'd8, 8'd9,
                                  8'd0, 8'd0, 8'd13, 8'd14, 8'd15});
        nz = 0;
        for (int t = 0; t < 25; t++) if (b_got0[t*8 +: 8] != 8'd0) nz++;
        check("b_win00_nonzero", nz, 9);
        check("b_frame2_start", b_f2, b_last + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
